uart_frame_arbiter: RTL

Round-robin scheduler that shares the single 11-byte UART frame transmitter between up to `N_REQ` frame sources. It selects one pending source, latches and holds its 88-bit frame, produces the start pulse the transmitter expects, and blocks further frames until the transmitter's fixed frame time, plus an inter-frame gap, has elapsed. It sits between the sensor and packet producers and the UART transmit block.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_frame_arbiter_rr.sv | 34 +++
 rtl/uart_frame_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART frame arbiter.
// Frame layout: 11 bytes, byte 0 in bits [7:0], sent first.
package uart_arb_pkg;

  localparam int FRAME_W       = 88;
  localparam int FRAME_BYTES   = 11;
  localparam int BITS_PER_BYTE = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // XOR of bytes 0..9; the last byte is reserved for this checksum.
  function automatic logic [7:0] frame_xor(input logic [FRAME_W-1:0] frame);
    logic [7:0] acc;
    acc = 8'h00;
    for (int b = 0; b < FRAME_BYTES - 1; b++) begin
      acc = acc ^ frame[8*b +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_rr.sv
// Combinational round-robin picker: searches upward from last+1 and wraps,
// returning the first pending requester as one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic w_found;
  int   w_idx;

  // Priority rotates so that the previous winner is examined last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(last) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        win[w_idx] = 1'b1;
        win_idx    = IDX_W'(w_idx);
        w_found    = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one 11-byte UART frame transmitter between N_REQ sources.
// Optional FRAME_CHECKSUM_EN replaces latched byte 10 with the XOR of bytes 0..9.
module uart_frame_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int CLK_FS    = 24000000,
  parameter int UART_BPS  = 460800,
  parameter int BPS_CNT   = CLK_FS / UART_BPS,
  parameter int GAP_BITS  = 2,
  parameter int EN_CYCLES = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*FRAME_W-1:0] req_data,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     txd_en,
  output logic [FRAME_W-1:0]       txd_data
);

  localparam int IDX_W        = $clog2(N_REQ);
  localparam int FRAME_CYCLES = (FRAME_BYTES * BITS_PER_BYTE + GAP_BITS) * BPS_CNT;
  localparam logic [19:0] LAST_CYC = 20'(FRAME_CYCLES - 1);
  localparam logic [19:0] EN_LAST  = 20'(EN_CYCLES - 1);

  if (FRAME_CYCLES >= (1 << 20)) begin : g_frame_too_long
    $error("FRAME_CYCLES does not fit the 20-bit cycle counter");
  end

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [19:0]          r_cyc_cnt;
  logic [19:0]          w_cyc_nxt;
  logic [IDX_W-1:0]     r_last;
  logic [N_REQ-1:0]     r_grant;
  logic                 r_busy;
  logic                 r_txd_en;
  logic [FRAME_W-1:0]   r_txd_data;
  logic [N_REQ-1:0]     w_win;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_take;
  logic [FRAME_W-1:0]   w_sel;
  logic [FRAME_W-1:0]   w_frame;
  logic [N_REQ-1:0]     w_grant_nxt;
  logic                 w_busy_nxt;
  logic                 w_txd_en_nxt;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .last    (r_last),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  assign w_take = (r_state == IDLE) && (|req);

  // Winner's frame, with byte 10 optionally replaced by the checksum.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) begin
        w_sel = req_data[FRAME_W*i +: FRAME_W];
      end else begin
        w_sel = w_sel;
      end
    end
`ifdef FRAME_CHECKSUM_EN
    w_frame = {frame_xor(w_sel), w_sel[FRAME_W-9:0]};
`else
    w_frame = w_sel;
`endif
  end

  // State register and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_cyc_cnt  <= 20'd0;
      r_last     <= IDX_W'(N_REQ - 1);
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_txd_en   <= 1'b0;
      r_txd_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_txd_en   <= w_txd_en_nxt;
      if (w_take) begin
        r_last     <= w_win_idx;
        r_txd_data <= w_frame;
      end
    end
  end

  // Next state; the counter runs from the grant edge through the whole frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = START; else w_state_nxt = IDLE;
      START:   if (r_cyc_cnt == EN_LAST) w_state_nxt = WAIT; else w_state_nxt = START;
      WAIT:    if (r_cyc_cnt == LAST_CYC) w_state_nxt = IDLE; else w_state_nxt = WAIT;
      default: w_state_nxt = IDLE;
    endcase
    if (r_state == IDLE || w_state_nxt == IDLE) begin
      w_cyc_nxt = 20'd0;
    end else begin
      w_cyc_nxt = r_cyc_cnt + 20'd1;
    end
  end

  // Output values to be registered on the next edge.
  always_comb begin
    w_grant_nxt  = w_take ? w_win : '0;
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_txd_en_nxt = (w_state_nxt == START);
  end

  assign grant    = r_grant;
  assign busy     = r_busy;
  assign txd_en   = r_txd_en;
  assign txd_data = r_txd_data;

endmodule
